pc_unit: RTL

Parametrised program-counter unit; successor to the single load-only PC register. Holds the current instruction address and advances it each cycle by increment, absolute load, PC-relative branch, call or return. Calls and returns use an internal return-address stack (RAS). Sits between the control unit (which drives `op`/`stall`) and the shared A/B buses, which it drives through independent tri-state enables.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ras.sv | 79 +++++++
 rtl/pc_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared op-code encoding for the program-counter unit and its control unit.
package pc_pkg;

  localparam int PC_OP_W = 3;

  typedef logic [PC_OP_W-1:0] pc_op_t;

  localparam pc_op_t PC_HOLD = 3'd0;
  localparam pc_op_t PC_INC  = 3'd1;
  localparam pc_op_t PC_LOAD = 3'd2;
  localparam pc_op_t PC_BREL = 3'd3;
  localparam pc_op_t PC_CALL = 3'd4;
  localparam pc_op_t PC_RET  = 3'd5;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is refused. Both cases are flagged as single-cycle events.
module pc_ras #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx_s;

  // ptr_q is the next slot to write; the power-of-two depth makes wrap free,
  // and when full the slot at ptr_q is also the oldest entry.
  assign top_idx_s = ptr_q - {{(PTR_W-1){1'b0}}, 1'b1};
  assign rdata     = mem_q[top_idx_s];
  assign empty     = (cnt_q == {CNT_W{1'b0}});
  assign full      = (cnt_q == DEPTH_C);
  assign ovf_evt   = push & full;
  assign unf_evt   = pop & ~push & empty;

  // Next pointer and occupancy
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      if (!full) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && !empty) begin
      ptr_d = top_idx_s;
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push) begin
      mem_q[ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, load, relative branch, call/return via an
// internal return-address stack, sticky stack error flags and bus drivers.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               INC       = 1,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_OP_W-1:0] op,
  input  logic               stall,
  input  logic [WIDTH-1:0]   Din,
  input  logic [WIDTH-1:0]   offset,
  input  logic               err_clr,
  input  logic               oeA,
  input  logic               oeB,
  output logic [WIDTH-1:0]   DA,
  output logic [WIDTH-1:0]   DB,
  output logic [WIDTH-1:0]   pc,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ovf,
  output logic               unf
);

  localparam logic [WIDTH-1:0] INC_C = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] ret_addr_s;
  logic             ovf_evt_s, unf_evt_s;

  assign push_s = ~stall & (op == PC_CALL);
  assign pop_s  = ~stall & (op == PC_RET);

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (pc_q + INC_C),
    .rdata   (ret_addr_s),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf_evt (ovf_evt_s),
    .unf_evt (unf_evt_s)
  );

  // Next-pc selection; a RET on an empty stack leaves pc where it is
  always_comb begin
    pc_d = pc_q;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (op)
        PC_HOLD: pc_d = pc_q;
        PC_INC:  pc_d = pc_q + INC_C;
        PC_LOAD: pc_d = Din;
        PC_BREL: pc_d = pc_q + offset;
        PC_CALL: pc_d = Din;
        PC_RET:  pc_d = ras_empty ? pc_q : ret_addr_s;
        default: pc_d = pc_q;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle as a clear keeps the flag set
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_evt_s) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // PC and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc  = pc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign DA  = oeA ? pc_q : {WIDTH{1'bz}};
  assign DB  = oeB ? pc_q : {WIDTH{1'bz}};

endmodule
